// File: rtl/alu_rotcmp_pipe.sv
// Rotate/compare ALU (ROL/ROR, unsigned+signed MAX/MIN, SGT/SLT) behind a 2-stage valid/ready pipeline.
// Latency: result valid 2 cycles after the beat is accepted; throughput 1 beat/cycle.
// Backpressure: out_ready low holds result/flags and S1; in_ready drops only when both stages are full.
module alu_rotcmp_pipe #(
    parameter int WIDTH   = 8,
    parameter int SHIFT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         opcode,
    input  logic [WIDTH-1:0]   input1,
    input  logic [WIDTH-1:0]   input2,
    input  logic [SHIFT_W-1:0] shiftValue,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               carryFlag,
    output logic               zeroFlag,
    output logic               overFlowFlag,
    output logic               opErr
);

    typedef struct packed {
        logic [3:0]         op;
        logic [WIDTH-1:0]   a;
        logic [WIDTH-1:0]   b;
        logic [SHIFT_W-1:0] sh;
    } beat_t;

    beat_t s1_dat;
    logic  s1_valid;
    logic  s1_ready;
    logic  s2_ready;

    assign s2_ready = !out_valid || out_ready;
    assign s1_ready = !s1_valid || s2_ready;
    assign in_ready = s1_ready;

    // ---------------------------------------------------------------- stage 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (s1_ready) begin
            s1_valid <= in_valid;
        end
    end

    // Payload is gated by s1_valid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (in_valid && s1_ready) begin
            s1_dat <= {opcode, input1, input2, shiftValue};
        end
    end

    // ---------------------------------------------------------------- stage 2 datapath
    logic [31:0]      amt;
    logic [WIDTH-1:0] rol_res;
    logic [WIDTH-1:0] ror_res;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic             sub_ovf;
    logic             s_gt;
    logic             s_lt;

    always_comb begin
        amt     = 32'(s1_dat.sh) % 32'(WIDTH);
        // Rotating a doubled copy of A leaves the wrapped bits in the kept half.
        rol_res = WIDTH'(({s1_dat.a, s1_dat.a} << amt) >> WIDTH);
        ror_res = WIDTH'({s1_dat.a, s1_dat.a} >> amt);
        diff    = {1'b0, s1_dat.a} - {1'b0, s1_dat.b};
        borrow  = diff[WIDTH];
        sub_ovf = (s1_dat.a[WIDTH-1] ^ s1_dat.b[WIDTH-1])
                & (diff[WIDTH-1] ^ s1_dat.a[WIDTH-1]);
        s_gt    = $signed(s1_dat.a) > $signed(s1_dat.b);
        s_lt    = $signed(s1_dat.a) < $signed(s1_dat.b);
    end

    logic [WIDTH-1:0] nxt_res;
    logic             nxt_carry;
    logic             nxt_zero;
    logic             nxt_ovf;
    logic             nxt_err;

    always_comb begin
        nxt_res   = '0;
        nxt_carry = 1'b0;
        nxt_ovf   = 1'b0;
        nxt_err   = 1'b0;
        case (s1_dat.op)
            4'd0: begin
                nxt_res   = rol_res;
                nxt_carry = (amt != 32'd0) && rol_res[0];
            end
            4'd1: begin
                nxt_res   = ror_res;
                nxt_carry = (amt != 32'd0) && ror_res[WIDTH-1];
            end
            4'd2: nxt_res = (s1_dat.a >= s1_dat.b) ? s1_dat.a : s1_dat.b;
            4'd3: nxt_res = (s1_dat.a <= s1_dat.b) ? s1_dat.a : s1_dat.b;
            4'd4: nxt_res = {{(WIDTH-1){1'b0}}, s_gt};
            4'd5: nxt_res = s_lt ? s1_dat.b : s1_dat.a;
            4'd6: nxt_res = s_gt ? s1_dat.b : s1_dat.a;
            4'd7: nxt_res = {{(WIDTH-1){1'b0}}, s_lt};
            default: nxt_err = 1'b1;
        endcase
        if (!s1_dat.op[3] && (s1_dat.op[2:1] != 2'b00)) begin
            nxt_carry = borrow;
            nxt_ovf   = sub_ovf;
        end
        nxt_zero = (nxt_res == '0);
    end

    // ---------------------------------------------------------------- stage 2 registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            result       <= '0;
            carryFlag    <= 1'b0;
            zeroFlag     <= 1'b0;
            overFlowFlag <= 1'b0;
            opErr        <= 1'b0;
        end else begin
            if (s2_ready) begin
                out_valid <= s1_valid;
            end
            if (s1_valid && s2_ready) begin
                result       <= nxt_res;
                carryFlag    <= nxt_carry;
                zeroFlag     <= nxt_zero;
                overFlowFlag <= nxt_ovf;
                opErr        <= nxt_err;
            end
        end
    end

endmodule

// File: tb/tb_alu_rotcmp_pipe.sv
// Directed + scoreboard bench for alu_rotcmp_pipe (WIDTH=8, SHIFT_W=5).
module tb_alu_rotcmp_pipe;
    localparam int W  = 8;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    opcode = '0;
    logic [W-1:0]  input1 = '0;
    logic [W-1:0]  input2 = '0;
    logic [SW-1:0] shiftValue = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  result;
    logic          carryFlag, zeroFlag, overFlowFlag, opErr;

    always #5 clk = ~clk;

    alu_rotcmp_pipe #(.WIDTH(W), .SHIFT_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .input1(input1), .input2(input2), .shiftValue(shiftValue),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .carryFlag(carryFlag), .zeroFlag(zeroFlag), .overFlowFlag(overFlowFlag),
        .opErr(opErr)
    );

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         z;
        logic         v;
        logic         e;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int outs = 0;
    int stalls = 0;
    int acc_cyc = -1;
    int first_out_cyc = -1;
    int last_out_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(logic [W-1:0] r, logic c, logic z, logic v, logic e);
        exp_t x;
        x.res = r; x.c = c; x.z = z; x.v = v; x.e = e;
        return x;
    endfunction

    function automatic exp_t model(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b,
                                   logic [SW-1:0] sh);
        exp_t x;
        int sa, sb, ua, ub, amt, d;
        logic [W-1:0] r;
        x = '0;
        sa = $signed(a); sb = $signed(b); ua = a; ub = b;
        amt = int'(sh) % W;
        d = sa - sb;
        r = a;
        if (op == 4'd0) begin
            for (int i = 0; i < amt; i++) r = {r[W-2:0], r[W-1]};
            x.c = (amt != 0) ? r[0] : 1'b0;
        end else if (op == 4'd1) begin
            for (int i = 0; i < amt; i++) r = {r[0], r[W-1:1]};
            x.c = (amt != 0) ? r[W-1] : 1'b0;
        end else if (op < 4'd8) begin
            case (op)
                4'd2: r = (ua >= ub) ? a : b;
                4'd3: r = (ua <= ub) ? a : b;
                4'd4: r = (sa > sb) ? 1 : 0;
                4'd5: r = (sa >= sb) ? a : b;
                4'd6: r = (sa <= sb) ? a : b;
                default: r = (sa < sb) ? 1 : 0;
            endcase
            x.c = (ua < ub);
            x.v = (d > (1 << (W-1)) - 1) || (d < -(1 << (W-1)));
        end else begin
            r = '0;
            x.e = 1'b1;
        end
        x.res = r;
        x.z = (r == '0);
        return x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: a beat is consumed at the posedge following a negedge with valid&&ready.
    always @(negedge clk) begin
        exp_t e;
        exp_t o;
        if (rst_n && out_valid && out_ready) begin
            o = mk(result, carryFlag, zeroFlag, overFlowFlag, opErr);
            tests++;
            if (q.size() == 0) begin
                fails++;
                $error("FAIL sb_unexpected observed=%h expected=no beat", o);
            end else begin
                e = q.pop_front();
                assert (o === e) else begin
                    fails++;
                    $error("FAIL sb_result observed=%h expected=%h", o, e);
                end
            end
            outs++;
            if (first_out_cyc < 0) first_out_cyc = cyc;
            last_out_cyc = cyc;
        end
    end

    // Leaves in_valid high on return so consecutive calls go back-to-back.
    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [SW-1:0] sh, input exp_t e);
        int n;
        opcode = op; input1 = a; input2 = b; shiftValue = sh; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            stalls++; n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            tests++; fails++;
            $error("FAIL send_timeout observed=in_ready 0 expected=1");
        end else begin
            q.push_back(e);
            if (acc_cyc < 0) acc_cyc = cyc;
        end
        @(posedge clk); #1;
    endtask

    task automatic sendm(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [SW-1:0] sh);
        send(op, a, b, sh, model(op, a, b, sh));
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk); n++;
        end
        chk(tag, q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {carryFlag, zeroFlag, overFlowFlag, opErr}, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;

        // Directed vectors
        send(4'd0, 8'h81, 8'h00, 5'd1, mk(8'h03, 1, 0, 0, 0));
        send(4'd0, 8'h81, 8'h00, 5'd8, mk(8'h81, 0, 0, 0, 0));
        send(4'd0, 8'h81, 8'h00, 5'd0, mk(8'h81, 0, 0, 0, 0));
        send(4'd1, 8'h01, 8'h00, 5'd9, mk(8'h80, 1, 0, 0, 0));
        send(4'd2, 8'h80, 8'h7F, 5'd0, mk(8'h80, 0, 0, 1, 0));
        send(4'd5, 8'h80, 8'h7F, 5'd0, mk(8'h7F, 0, 0, 1, 0));
        send(4'd4, 8'h80, 8'h7F, 5'd0, mk(8'h00, 0, 1, 1, 0));
        send(4'd3, 8'h00, 8'h00, 5'd0, mk(8'h00, 0, 1, 0, 0));
        send(4'd9, 8'h12, 8'h34, 5'd3, mk(8'h00, 0, 1, 0, 1));
        send(4'd0, 8'h5A, 8'h00, 5'd4, mk(8'hA5, 1, 0, 0, 0));
        send(4'd7, 8'hFF, 8'h01, 5'd0, mk(8'h01, 0, 0, 0, 0));
        send(4'd6, 8'h05, 8'h05, 5'd0, mk(8'h05, 0, 0, 0, 0));
        idle();
        drain("directed_drain");

        // Back-to-back 8 beats
        acc_cyc = -1; first_out_cyc = -1; outs = 0; stalls = 0;
        for (int i = 0; i < 8; i++) begin
            sendm(4'(i), 8'($urandom), 8'($urandom), 5'($urandom));
        end
        idle();
        drain("b2b_drain");
        chk("b2b_latency", first_out_cyc - acc_cyc, 2);
        chk("b2b_count", outs, 8);
        chk("b2b_consecutive", last_out_cyc - first_out_cyc, 7);
        chk("b2b_no_stall", stalls, 0);

        // Stall with continuous in_valid
        out_ready = 1'b0;
        send(4'd2, 8'h10, 8'h20, 5'd0, mk(8'h20, 1, 0, 0, 0));
        send(4'd1, 8'h0F, 8'h00, 5'd4, mk(8'hF0, 1, 0, 0, 0));
        opcode = 4'd3; input1 = 8'h44; input2 = 8'h22; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_result_hold", {result, carryFlag}, {8'h20, 1'b1});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        sendm(4'd3, 8'h44, 8'h22, 5'd0);
        sendm(4'd6, 8'h90, 8'h10, 5'd0);
        idle();
        drain("stall_drain");

        // Reset with two beats in flight
        send(4'd0, 8'h81, 8'h00, 5'd1, mk(8'h03, 1, 0, 0, 0));
        send(4'd2, 8'h55, 8'h33, 5'd0, mk(8'h55, 0, 0, 0, 0));
        idle();
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_flags", {carryFlag, zeroFlag, overFlowFlag, opErr}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_stale", out_valid, 0);
        end
        @(posedge clk); #1;
        sendm(4'd1, 8'h3C, 8'h00, 5'd2);
        idle();
        drain("post_rst_drain");

        // Random mix with gaps
        for (int i = 0; i < 24; i++) begin
            sendm(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 5'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                idle();
                @(posedge clk); #1;
            end
        end
        idle();
        drain("rand_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
